// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-bus round-robin arbiter.
// Destination decode lives here so the arbiter and its users agree on it.
package bus_arb_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, XFER} arb_state_e;

   localparam int ID_W      = 8;
   localparam int PKT_MAX   = 64;
   localparam int DRVRS_MAX = 32;

   // Destination ID sits in the top byte of a packet that is width bits wide.
   function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX-1:0] pkt, input int width);
      return pkt[width-1 -: ID_W];
   endfunction

   // Push mask for a packet; zero means the ID is invalid and the packet is dropped.
   function automatic logic [DRVRS_MAX-1:0] dest_mask(input logic [ID_W-1:0] id,
                                                      input int src,
                                                      input int drvrs,
                                                      input logic [ID_W-1:0] bcast);
      logic [DRVRS_MAX-1:0] mask;
      mask = '0;
      if (id == bcast) begin
         for (int i = 0; i < drvrs; i++) mask[i] = (i != src);
      end else if (int'(id) < drvrs) begin
         mask[id[4:0]] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Bus between the per-driver FIFOs and the arbiter: FIFO heads in, pop/push strobes and shared data out.
interface bus_rr_arbiter_if #(
   parameter int drvrs   = 4,
   parameter int pckg_sz = 16
);
   logic [drvrs-1:0]              pndng;
   logic [drvrs-1:0][pckg_sz-1:0] D_pop;
   logic [drvrs-1:0]              pop;
   logic [drvrs-1:0]              push;
   logic [pckg_sz-1:0]            D_push;

   modport master (input pndng, D_pop, output pop, push, D_push);
   modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request strictly after ptr, wrapping.
module rr_pick #(
   parameter int drvrs = 4,
   localparam int IDW  = $clog2(drvrs)
) (
   input  logic [drvrs-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [IDW-1:0]   idx,
   output logic             any
);
   int cand;

   // Scan from the farthest offset down so the nearest set request wins.
   always_comb begin
      idx  = ptr;
      any  = |req;
      cand = 0;
      for (int off = drvrs; off >= 1; off--) begin
         cand = int'(ptr) + off;
         if (cand >= drvrs) cand = cand - drvrs;
         if (req[IDW'(cand)]) idx = IDW'(cand);
      end
   end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and transfer sequencer: grant one FIFO, pop it, push the
// packet to its destination port(s), or drop and count packets with bad IDs.
module bus_rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter logic [ID_W-1:0] broadcast = 8'hFF,
   localparam int             IDW       = $clog2(drvrs)
) (
   input  logic             clk,
   input  logic             reset,
   bus_rr_arbiter_if.master bus,
   output logic [IDW-1:0]   gnt_id,
   output logic             busy,
   output logic             drop,
   output logic [7:0]       drop_cnt
);
   arb_state_e         state_reg, state_next;
   logic [IDW-1:0]     gnt_reg, gnt_next;
   logic [IDW-1:0]     rr_ptr_reg, rr_ptr_next;
   logic [pckg_sz-1:0] pkt_reg, pkt_next;
   logic [drvrs-1:0]   pop_reg, pop_next;
   logic [drvrs-1:0]   push_reg, push_next;
   logic               busy_reg, busy_next;
   logic               drop_reg, drop_next;
   logic [7:0]         cnt_reg, cnt_next;

   logic [IDW-1:0]       pick_idx;
   logic                 pick_any;
   logic [pckg_sz-1:0]   head;
   logic [PKT_MAX-1:0]   head_wide;
   logic [DRVRS_MAX-1:0] mask_full;

   rr_pick #(.drvrs(drvrs)) u_pick (
      .req (bus.pndng),
      .ptr (rr_ptr_reg),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      head                     = bus.D_pop[gnt_reg];
      head_wide                = '0;
      head_wide[pckg_sz-1:0]   = head;
      mask_full                = dest_mask(dest_id(head_wide, pckg_sz), int'(gnt_reg), drvrs, broadcast);
   end

   always_comb begin
      state_next  = state_reg;
      gnt_next    = gnt_reg;
      rr_ptr_next = rr_ptr_reg;
      pkt_next    = pkt_reg;
      pop_next    = '0;
      push_next   = '0;
      drop_next   = 1'b0;
      cnt_next    = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               gnt_next           = pick_idx;
               pop_next[pick_idx] = 1'b1;
               state_next         = GRANT;
            end
         end
         GRANT: begin
            // The push mask is registered alongside the packet so XFER outputs come straight from flops.
            pkt_next    = head;
            push_next   = mask_full[drvrs-1:0];
            rr_ptr_next = gnt_reg;
            if (mask_full == '0) begin
               drop_next = 1'b1;
               if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
            end
            state_next = XFER;
         end
         XFER: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         gnt_reg    <= '0;
         rr_ptr_reg <= IDW'(drvrs - 1);
         pkt_reg    <= '0;
         pop_reg    <= '0;
         push_reg   <= '0;
         busy_reg   <= 1'b0;
         drop_reg   <= 1'b0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         gnt_reg    <= gnt_next;
         rr_ptr_reg <= rr_ptr_next;
         pkt_reg    <= pkt_next;
         pop_reg    <= pop_next;
         push_reg   <= push_next;
         busy_reg   <= busy_next;
         drop_reg   <= drop_next;
         cnt_reg    <= cnt_next;
      end
   end

   assign bus.pop    = pop_reg;
   assign bus.push   = push_reg;
   assign bus.D_push = pkt_reg;
   assign gnt_id     = gnt_reg;
   assign busy       = busy_reg;
   assign drop       = drop_reg;
   assign drop_cnt   = cnt_reg;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: unicast, rotation, broadcast, drop/saturation,
// reset during a transfer and self-send, with hand-computed expectations.
module tb_bus_rr_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] gnt_id;
   logic       busy;
   logic       drop;
   logic [7:0] drop_cnt;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   bus_rr_arbiter_if #(.drvrs(4), .pckg_sz(16)) bus ();

   bus_rr_arbiter #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.master),
      .gnt_id   (gnt_id),
      .busy     (busy),
      .drop     (drop),
      .drop_cnt (drop_cnt)
   );

   task automatic step();
      @(negedge clk);
   endtask

   // Offer one packet from one port, wait (bounded) for its pop, then sample the XFER cycle.
   task automatic send(input int port, input logic [15:0] pkt, input bit quiet,
                       output logic [3:0] pop_o, output logic [3:0] push_o,
                       output logic [15:0] data_o, output logic drop_o);
      int n;
      bus.D_pop[port] = pkt;
      bus.pndng       = 4'b0001 << port;
      for (n = 0; n < 8; n++) begin
         step();
         if (bus.pop != 4'b0000) break;
      end
      pop_o     = bus.pop;
      bus.pndng = 4'b0000;
      checks++;
      if (n == 8) begin
         failures++;
         $display("FAIL send_timeout port=%0d got pop=%b required a pop within 8 cycles", port, bus.pop);
      end
      step();
      push_o = bus.push;
      data_o = bus.D_push;
      drop_o = drop;
      if (!quiet)
         $display("xfer src=%0d pkt=%h pop=%b push=%b data=%h drop=%b drop_cnt=%0d",
                  port, pkt, pop_o, push_o, data_o, drop_o, drop_cnt);
   endtask

   task automatic test_reset();
      bus.pndng = 4'b0000;
      bus.D_pop = '0;
      reset     = 1'b0;
      step();
      step();
      checks++;
      if ({bus.pop, bus.push, bus.D_push, gnt_id, busy, drop, drop_cnt} !== 38'd0) begin
         failures++;
         $display("FAIL reset_outputs got pop=%b push=%b D_push=%h gnt=%0d busy=%b drop=%b cnt=%0d required all zero",
                  bus.pop, bus.push, bus.D_push, gnt_id, busy, drop, drop_cnt);
      end
      reset = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || bus.pop !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle got busy=%b pop=%b required busy=0 pop=0000", busy, bus.pop);
      end
      $display("reset done");
   endtask

   task automatic test_unicast();
      bus.D_pop[2] = 16'h01AB;
      bus.pndng    = 4'b0100;
      step();
      checks++;
      if (bus.pop !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
         failures++;
         $display("FAIL unicast_pop got pop=%b gnt=%0d busy=%b required pop=0100 gnt=2 busy=1", bus.pop, gnt_id, busy);
      end
      bus.pndng = 4'b0000;
      step();
      checks++;
      if (bus.push !== 4'b0010 || bus.D_push !== 16'h01AB || drop !== 1'b0 || bus.pop !== 4'b0000) begin
         failures++;
         $display("FAIL unicast_push got push=%b D_push=%h drop=%b pop=%b required push=0010 D_push=01ab drop=0 pop=0000",
                  bus.push, bus.D_push, drop, bus.pop);
      end
      step();
      checks++;
      if (bus.push !== 4'b0000 || busy !== 1'b0 || bus.D_push !== 16'h01AB) begin
         failures++;
         $display("FAIL unicast_after got push=%b busy=%b D_push=%h required push=0000 busy=0 D_push=01ab",
                  bus.push, busy, bus.D_push);
      end
      $display("xfer src=2 pkt=01ab unicast to port 1");
   endtask

   task automatic test_rotation();
      logic [3:0] exp_pop;
      logic [3:0] exp_push;
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) bus.D_pop[i] = 16'(i * 256 + 16 + i);
      bus.pndng = 4'b1111;
      for (int c = 1; c <= 12; c++) begin
         step();
         exp_pop = (c % 3 == 1) ? (4'b0001 << ((c - 1) / 3)) : 4'b0000;
         checks++;
         if (bus.pop !== exp_pop) begin
            failures++;
            $display("FAIL rotation_pop cycle=%0d got pop=%b required %b", c, bus.pop, exp_pop);
         end
         if (c % 3 == 2) begin
            exp_push = 4'b0001 << ((c - 2) / 3);
            checks++;
            if (bus.push !== exp_push || bus.D_push !== 16'((c - 2) / 3 * 257 + 16)) begin
               failures++;
               $display("FAIL rotation_push cycle=%0d got push=%b D_push=%h required push=%b D_push=%h",
                        c, bus.push, bus.D_push, exp_push, 16'((c - 2) / 3 * 257 + 16));
            end
            $display("xfer src=%0d pkt=%h rotation", (c - 2) / 3, bus.D_push);
         end
      end
      bus.pndng = 4'b0000;
      step();
   endtask

   task automatic test_broadcast();
      logic [3:0]  p, q;
      logic [15:0] d;
      logic        dr;
      send(1, 16'hFF55, 1'b0, p, q, d, dr);
      checks++;
      if (p !== 4'b0010 || q !== 4'b1101 || d !== 16'hFF55 || dr !== 1'b0) begin
         failures++;
         $display("FAIL broadcast got pop=%b push=%b D_push=%h drop=%b required pop=0010 push=1101 D_push=ff55 drop=0",
                  p, q, d, dr);
      end
   endtask

   task automatic test_drop();
      logic [3:0]  p, q;
      logic [15:0] d;
      logic        dr;
      send(0, 16'h07AA, 1'b0, p, q, d, dr);
      checks++;
      if (q !== 4'b0000 || dr !== 1'b1 || drop_cnt !== 8'd1) begin
         failures++;
         $display("FAIL drop_first got push=%b drop=%b cnt=%0d required push=0000 drop=1 cnt=1", q, dr, drop_cnt);
      end
      step();
      checks++;
      if (drop !== 1'b0 || drop_cnt !== 8'd1) begin
         failures++;
         $display("FAIL drop_pulse got drop=%b cnt=%0d required drop=0 cnt=1", drop, drop_cnt);
      end
      for (int i = 2; i <= 300; i++) begin
         send(0, 16'h07AA, 1'b1, p, q, d, dr);
         if (i == 254 || i == 255) begin
            checks++;
            if (drop_cnt !== 8'(i)) begin
               failures++;
               $display("FAIL drop_count n=%0d got cnt=%0d required %0d", i, drop_cnt, i);
            end
         end
      end
      checks++;
      if (drop_cnt !== 8'd255) begin
         failures++;
         $display("FAIL drop_saturate got cnt=%0d required 255", drop_cnt);
      end
      $display("xfer src=0 pkt=07aa dropped 300 times cnt=%0d", drop_cnt);
   endtask

   task automatic test_reset_mid_xfer();
      logic [3:0]  p, q;
      logic [15:0] d;
      logic        dr;
      send(2, 16'h0300, 1'b0, p, q, d, dr);
      checks++;
      if (q !== 4'b1000) begin
         failures++;
         $display("FAIL midreset_pre got push=%b required 1000", q);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.push !== 4'b0000 || bus.pop !== 4'b0000 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
         failures++;
         $display("FAIL midreset_clear got push=%b pop=%b busy=%b cnt=%0d required push=0000 pop=0000 busy=0 cnt=0",
                  bus.push, bus.pop, busy, drop_cnt);
      end
      step();
      reset        = 1'b1;
      bus.D_pop[1] = 16'h0021;
      bus.D_pop[3] = 16'h0023;
      bus.pndng    = 4'b1010;
      step();
      checks++;
      if (bus.pop !== 4'b0010 || gnt_id !== 2'd1) begin
         failures++;
         $display("FAIL midreset_first got pop=%b gnt=%0d required pop=0010 gnt=1", bus.pop, gnt_id);
      end
      bus.pndng = 4'b0000;
      step();
      step();
      $display("xfer src=1 pkt=0021 after reset");
   endtask

   task automatic test_self_send();
      logic [3:0]  p, q;
      logic [15:0] d;
      logic        dr;
      send(3, 16'h0312, 1'b0, p, q, d, dr);
      checks++;
      if (p !== 4'b1000 || q !== 4'b1000 || d !== 16'h0312 || gnt_id !== 2'd3 || dr !== 1'b0) begin
         failures++;
         $display("FAIL self_send got pop=%b push=%b D_push=%h gnt=%0d drop=%b required pop=1000 push=1000 D_push=0312 gnt=3 drop=0",
                  p, q, d, gnt_id, dr);
      end
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_rotation();
      test_broadcast();
      test_drop();
      test_reset_mid_xfer();
      test_self_send();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter and transfer sequencer for the shared packet bus. It watches the `pndng` flags of every driver-side FIFO and grants one source at a time. It pops that source's packet, decodes the destination ID in the packet's top byte, and pushes the packet to the addressed port. For the broadcast ID it pushes to every port except the source. It sits between the per-driver FIFOs and the bus interface (`bus_if`), replacing ad-hoc sequencing of pop/push.

## Interface
- `drvrs`, 4: number of ports; must be ≥2.
- `pckg_sz`, 16: packet width in bits; must be ≥9.
- `broadcast`, 8'hFF: destination ID meaning "all ports".
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pndng` in [drvrs]: per-port "FIFO not empty".
- `D_pop` in [drvrs][pckg_sz]: per-port FIFO head data, first-word-fall-through (valid while `pndng`=1).
- `pop` out [drvrs]: one-hot, one-cycle FIFO pop strobe.
- `push` out [drvrs]: one-cycle push strobes to destination ports; one-hot, or multi-hot for broadcast.
- `D_push` out [pckg_sz]: shared bus data, valid while any `push` bit is 1.
- `gnt_id` out [$clog2(drvrs)]: index of the current/last granted source.
- `busy` out 1: high in GRANT and XFER states.
- `drop` out 1: one-cycle pulse when a packet is discarded for an invalid ID.
- `drop_cnt` out 8: saturating count of dropped packets.

## Operation
- Destination ID is `pkt[pckg_sz-1 -: 8]`.
- A valid ID is `< drvrs` or equal to `broadcast`.
- FSM states: IDLE, GRANT, XFER.
- IDLE:
  - If any `pndng` bit is set, select the first set index strictly after `rr_ptr`, wrapping modulo `drvrs`.
  - Register the selection into `gnt_id`; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Assert `pop[gnt_id]` for exactly one cycle.
  - Capture `D_pop[gnt_id]` into the packet register.
  - Set `rr_ptr <= gnt_id`; go to XFER.
- XFER:
  - Drive `D_push` from the packet register.
  - Valid unicast ID: `push` = one-hot(ID).
  - ID = `broadcast`: `push` = all ones with the `gnt_id` bit cleared.
  - Unicast ID equal to `gnt_id` (self-send): delivered normally, push[gnt_id]=1.
  - Invalid ID: `push` stays 0, `drop` pulses, `drop_cnt` increments and saturates at 255.
  - Return to IDLE.
- Fairness: a port that just won is last in priority for the next arbitration. With all ports pending, grants rotate 0,1,2,…,drvrs-1,0.
- `pndng` is sampled only in IDLE. A port deasserting `pndng` during GRANT is the FIFO's fault; the arbiter still pops and forwards the captured data.
- `D_push` holds its last value outside XFER. Only `push` qualifies it.

## Timing
- Reset values (asynchronous on `reset`=0):
  - state=IDLE.
  - `rr_ptr`=drvrs-1, so the first grant goes to port 0.
  - `pop`=0, `push`=0, `D_push`=0, `gnt_id`=0, `busy`=0, `drop`=0, `drop_cnt`=0.
- Latency: `pndng` high at edge n (in IDLE) → `pop` high during cycle n+1 → `push`/`D_push` valid during cycle n+2.
- Throughput: one packet per 3 cycles. With back-to-back pending traffic, IDLE lasts exactly one cycle.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-GRANT or mid-XFER aborts immediately and clears `pop`/`push`. A packet already popped is lost and is not counted as a drop.
- Simultaneous requests: exactly one pop per GRANT; never two `pop` bits set.

## Structure
- Shared package `bus_arb_pkg`:
  - state enum `arb_state_e` {IDLE, GRANT, XFER};
  - constant `ID_W`=8;
  - function `dest_id(pkt)`;
  - function `dest_mask(id, src, drvrs)`, returning the push mask (zero for invalid).
- One sub-module: `rr_pick`, a combinational rotate-priority encoder. Inputs: `req[drvrs]`, `ptr`. Outputs: `idx`, `any`.
- The top level holds the FSM, packet register, `rr_ptr` and counter.

## Test plan
- Reset, then `pndng`=4'b0100 with `D_pop[2]`=16'h01AB → `pop`=4'b0100 one cycle later, then `push`=4'b0010, `D_push`=16'h01AB; `gnt_id`=2.
- `pndng`=4'b1111 held for 12 cycles → grant order 0,1,2,3; `pop` asserts every 3rd cycle, always one-hot.
- Port 1 sends 16'hFF55 (broadcast) → `push`=4'b1101, `D_push`=16'hFF55, `drop`=0.
- Port 0 sends 16'h07AA (ID 7 ≥ drvrs) → `push`=0, `drop` pulses once, `drop_cnt`=1; 300 such packets → `drop_cnt`=255.
- Reset driven low during XFER of 16'h0300 → `push`=0 in the same cycle; after release, the first grant goes to the lowest pending port.
- Port 3 sends 16'h0312 (self-send) → `push`=4'b1000, `D_push`=16'h0312.
